// File: rtl/gascon_arb_pkg.sv
// Shared types for the Gascon round arbiter: FSM states, port index type and port count.
package gascon_arb_pkg;

   localparam int unsigned NPORTS = 2;

   typedef logic [0:0] port_idx_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      NEXT,
      FINISH
   } arb_state_e;

   // Index of the set bit in a two-port one-hot grant (0 when port 0 or nobody owns).
   function automatic port_idx_t grant_to_idx(input logic [NPORTS-1:0] grant);
      return port_idx_t'(grant[1]);
   endfunction

endpackage

// File: rtl/gascon_rr_pick.sv
// Combinational two-way round-robin pick: a lone requester wins, and a tie goes to
// the port that did not own the core last.
module gascon_rr_pick
   import gascon_arb_pkg::*;
(
   input  logic [NPORTS-1:0] req,
   input  port_idx_t         last,
   output logic [NPORTS-1:0] win_c
);

   always_comb begin
      win_c = '0;
      if (&req) begin
         win_c[~last] = 1'b1;
      end else begin
         win_c = req;
      end
   end

endmodule

// File: rtl/gascon_round_arbiter.sv
// Time-shares one single-round Gascon core between the key-schedule engine (port 0)
// and the encryption/mix datapath (port 1), iterating the core for the requested rounds.
module gascon_round_arbiter
   import gascon_arb_pkg::*;
#(
   parameter int unsigned CWIDTH  = 128,
   parameter int unsigned RCW     = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [CWIDTH-1:0] cin0,
   input  logic [CWIDTH-1:0] cin1,
   input  logic [RCW-1:0]    nrounds0,
   input  logic [RCW-1:0]    nrounds1,
   output logic [1:0]        grant,
   output logic [1:0]        done,
   output logic [CWIDTH-1:0] cout,
   output logic              err,
   output logic              busy,
   output logic [CWIDTH-1:0] core_c,
   output logic              core_reset,
   output logic              core_round,
   input  logic [CWIDTH-1:0] core_cout,
   input  logic              core_done
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   arb_state_e        state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic [CWIDTH-1:0] w_q, w_d;
   logic [RCW-1:0]    cnt_q, cnt_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   port_idx_t         last_q, last_d;
   logic [1:0]        done_q, done_d;
   logic [CWIDTH-1:0] cout_q, cout_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic [CWIDTH-1:0] core_c_q, core_c_d;
   logic              core_reset_q, core_reset_d;

   logic [1:0]        win_c;
   logic              win_sel_c;
   logic [RCW-1:0]    win_n_c;

   gascon_rr_pick u_pick (
      .req   (req),
      .last  (last_q),
      .win_c (win_c)
   );

   assign win_sel_c = win_c[1];
   assign win_n_c   = win_sel_c ? nrounds1 : nrounds0;

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      w_d      = w_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      last_d   = last_q;
      done_d   = '0;
      cout_d   = cout_q;
      err_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = win_c;
               w_d     = win_sel_c ? cin1 : cin0;
               cnt_d   = win_n_c;
               state_d = (win_n_c == '0) ? FINISH : LOAD;
            end
         end
         LOAD: begin
            tmo_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            // A core_done in the threshold cycle still counts as a completed round.
            if (core_done) begin
               w_d     = core_cout;
               cnt_d   = cnt_q - RCW'(1);
               state_d = NEXT;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (tmo_d == TW'(TIMEOUT)) begin
                  err_d   = 1'b1;
                  cout_d  = w_q;
                  state_d = FINISH;
               end
            end
         end
         NEXT: begin
            state_d = (cnt_q != '0) ? LOAD : FINISH;
         end
         FINISH: begin
            done_d  = grant_q;
            cout_d  = w_q;
            last_d  = grant_to_idx(grant_q);
            grant_d = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d       = |grant_d;
      core_reset_d = (state_d == LOAD);
      core_c_d     = (state_d == LOAD) ? w_d : core_c_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         w_q          <= '0;
         cnt_q        <= '0;
         tmo_q        <= '0;
         last_q       <= port_idx_t'(1'b1);
         done_q       <= '0;
         cout_q       <= '0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         core_c_q     <= '0;
         core_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         w_q          <= w_d;
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
         last_q       <= last_d;
         done_q       <= done_d;
         cout_q       <= cout_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         core_c_q     <= core_c_d;
         core_reset_q <= core_reset_d;
      end
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign cout       = cout_q;
   assign err        = err_q;
   assign busy       = busy_q;
   assign core_c     = core_c_q;
   assign core_reset = core_reset_q;
   assign core_round = 1'b0;

endmodule

// File: tb/tb_gascon_round_arbiter.sv
// Bench for gascon_round_arbiter: behavioural Gascon core stand-in plus an operation-level
// reference (round-robin owner, iterated round function, cycle latency) for each request.
module tb_gascon_round_arbiter;

   localparam int unsigned CW      = 128;
   localparam int          TIMEOUT = 64;
   localparam logic [CW-1:0] KMIX  = 128'h9e3779b97f4a7c15_f39cc0605cedc834;

   logic          clk;
   logic          reset;
   logic [1:0]    req;
   logic [CW-1:0] cin0, cin1;
   logic [3:0]    nrounds0, nrounds1;
   logic [1:0]    grant, done;
   logic [CW-1:0] cout;
   logic          err, busy;
   logic [CW-1:0] core_c;
   logic          core_reset, core_round;
   logic [CW-1:0] core_cout;
   logic          core_done;

   logic [1:0]    req_v;
   logic [CW-1:0] cin_v [2];
   logic [3:0]    n_v [2];
   int            last_m;
   int            lat_v;
   bit            hang;
   int            ccnt;
   int            checks;
   int            errors;
   int            rc_cnt;
   int            err_cnt;

   assign req      = req_v;
   assign cin0     = cin_v[0];
   assign cin1     = cin_v[1];
   assign nrounds0 = n_v[0];
   assign nrounds1 = n_v[1];

   gascon_round_arbiter #(.CWIDTH(CW), .RCW(4), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .cin0       (cin0),
      .cin1       (cin1),
      .nrounds0   (nrounds0),
      .nrounds1   (nrounds1),
      .grant      (grant),
      .done       (done),
      .cout       (cout),
      .err        (err),
      .busy       (busy),
      .core_c     (core_c),
      .core_reset (core_reset),
      .core_round (core_round),
      .core_cout  (core_cout),
      .core_done  (core_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [CW-1:0] core_f(input logic [CW-1:0] x);
      return {x[122:0], x[127:123]} ^ (x >> 7) ^ KMIX;
   endfunction

   function automatic logic [CW-1:0] ref_rounds(input logic [CW-1:0] x, input int n);
      logic [CW-1:0] y;
      y = x;
      for (int i = 0; i < n; i++) y = core_f(y);
      return y;
   endfunction

   function automatic int pick_m(input logic [1:0] r, input int last);
      if (r == 2'b11) return (last == 0) ? 1 : 0;
      if (r[0]) return 0;
      return 1;
   endfunction

   function automatic logic [CW-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Core stand-in: done lat_v cycles after its reset is released; hang suppresses done.
   always @(posedge clk or posedge reset) begin
      if (reset || core_reset) ccnt <= 0;
      else ccnt <= ccnt + 1;
   end
   assign core_done = !hang && !core_reset && (ccnt == lat_v - 1);
   assign core_cout = core_f(core_c);

   always @(negedge clk) begin
      if (!reset) begin
         if (core_reset) rc_cnt++;
         if (err) err_cnt++;
         checks++;
         assert ($onehot0(grant) && (busy === (|grant) && core_round === 1'b0)) else begin
            errors++;
            $error("FAIL grant_invariant observed grant=%b busy=%b round=%b expected one-hot-or-zero grant, busy=|grant, round=0",
                   grant, busy, core_round);
         end
      end
   end

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_grant", 128'(grant), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_cout", cout, 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_core_c", core_c, 128'(0));
      chk("rst_core_reset", 128'(core_reset), 128'(1));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1 chk_reset_state();
      @(negedge clk);
      #2 reset = 1'b0;
      last_m = 1;
   endtask

   // One arbitration from an IDLE boundary to the owner's done pulse.
   task automatic run_op(input bit hang_op, input bit keep, input bit mid);
      int w, n, k, exp_k, err_k, rc0, ec0, exp_rc, exp_err;
      logic [CW-1:0] exp_c;
      logic [1:0] oh;
      bit seen, gr_ok;
      w      = pick_m(req_v, last_m);
      oh     = 2'(1 << w);
      n      = int'(n_v[w]);
      exp_c  = ref_rounds(cin_v[w], n);
      exp_k  = (n == 0) ? 2 : 2 + n * (lat_v + 2);
      exp_rc = n;
      exp_err = 0;
      if (hang_op && n != 0) begin
         exp_c   = cin_v[w];
         exp_k   = TIMEOUT + 3;
         exp_rc  = 1;
         exp_err = 1;
      end
      rc0 = rc_cnt; ec0 = err_cnt; err_k = 0; seen = 1'b0; gr_ok = 1'b1; k = 0;
      while (!seen && k < 500) begin
         @(negedge clk);
         k++;
         if (done != 2'b00) seen = 1'b1;
         else if (grant !== oh) gr_ok = 1'b0;
         if (err === 1'b1 && err_k == 0) err_k = k;
         if (k == 1 && !seen) begin
            cin_v[w] = rand128();
            n_v[w]   = 4'($urandom_range(0, 4));
         end
         if (mid && k == 1) req_v[1 - w] = 1'b1;
         if (mid && k == 3) req_v[w] = 1'b0;
      end
      chk("done_seen", 128'(seen), 128'(1));
      chk("done_owner", 128'(done), 128'(oh));
      chk("latency", 128'(k), 128'(exp_k));
      chk("cout", cout, exp_c);
      chk("grant_held", 128'(gr_ok), 128'(1));
      chk("grant_clear_at_done", 128'(grant), 128'(0));
      chk("load_pulses", 128'(rc_cnt - rc0), 128'(exp_rc));
      chk("err_pulses", 128'(err_cnt - ec0), 128'(exp_err));
      if (exp_err != 0) chk("err_time", 128'(err_k), 128'(TIMEOUT + 2));
      last_m = w;
      if (!keep) req_v[w] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed no end of run expected completion");
      $fatal(1);
   end

   initial begin
      checks = 0; errors = 0; rc_cnt = 0; err_cnt = 0;
      req_v = 2'b00; cin_v[0] = '0; cin_v[1] = '0; n_v[0] = '0; n_v[1] = '0;
      hang = 1'b0; lat_v = 2; last_m = 1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_state();
      #2 reset = 1'b0;

      // Port 0 alone, three rounds from C=1.
      req_v = 2'b01; cin_v[0] = 128'h1; n_v[0] = 4'd3;
      run_op(1'b0, 1'b0, 1'b0);

      // Simultaneous requests after reset: port 0 first, then strict alternation.
      apply_reset();
      req_v = 2'b11;
      cin_v[0] = rand128(); n_v[0] = 4'd2;
      cin_v[1] = rand128(); n_v[1] = 4'd1;
      run_op(1'b0, 1'b1, 1'b0);
      run_op(1'b0, 1'b1, 1'b0);
      run_op(1'b0, 1'b0, 1'b0);
      run_op(1'b0, 1'b0, 1'b0);

      // Zero rounds: pass-through with no core activity.
      req_v = 2'b10; cin_v[1] = 128'hABCD; n_v[1] = 4'd0;
      run_op(1'b0, 1'b0, 1'b0);

      // Hung core on port 0 with port 1 pending.
      hang = 1'b1;
      req_v = 2'b11;
      cin_v[0] = rand128(); n_v[0] = 4'd3;
      cin_v[1] = rand128(); n_v[1] = 4'd2;
      run_op(1'b1, 1'b0, 1'b0);
      hang = 1'b0;
      run_op(1'b0, 1'b0, 1'b0);

      // Reset in the middle of a five-round op, then the held request reruns in full.
      req_v = 2'b01; cin_v[0] = rand128(); n_v[0] = 4'd5;
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1 chk_reset_state();
      @(negedge clk);
      #2 reset = 1'b0;
      last_m = 1;
      run_op(1'b0, 1'b0, 1'b0);

      // Port 0 drops req mid-op while port 1 starts waiting.
      req_v = 2'b01; cin_v[0] = rand128(); n_v[0] = 4'd3;
      cin_v[1] = rand128(); n_v[1] = 4'd2;
      run_op(1'b0, 1'b0, 1'b1);
      run_op(1'b0, 1'b0, 1'b0);

      // Random request mixes, round counts and core latencies.
      for (int i = 0; i < 24; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!req_v[p] && $urandom_range(0, 1) == 1) begin
               req_v[p] = 1'b1;
               cin_v[p] = rand128();
               n_v[p]   = 4'($urandom_range(0, 4));
            end
         end
         if (req_v == 2'b00) begin
            req_v[$urandom_range(0, 1)] = 1'b1;
         end
         lat_v = int'($urandom_range(1, 4));
         run_op(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gascon_round_arbiter.md
Name: gascon_round_arbiter

Overview:
- Time-shares one single-round Gascon core between two requesters: port 0 is the key-schedule engine and port 1 is the encryption/mix datapath.
- Grants one requester at a time, using round-robin order.
- Runs the requested number of rounds by feeding the core output back to the core input.
- Returns the final C and a done pulse to the owner.
- Sits between the requester FSMs and the Gascon_Core_Round instance, and drives that core's c/reset/round pins.

Parameters:
- CWIDTH, 128, state width C in bits.
- RCW, 4, width of round-count request (max 2^RCW-1 rounds).
- TIMEOUT, 64, max cycles to wait for core_done per round before error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req  in  2  request per port; level, held until own done pulse
- cin0  in  CWIDTH  port 0 initial C, sampled at grant
- cin1  in  CWIDTH  port 1 initial C, sampled at grant
- nrounds0  in  RCW  port 0 round count, sampled at grant
- nrounds1  in  RCW  port 1 round count, sampled at grant
- grant  out  2  one-hot owner, held for the whole operation
- done  out  2  one-cycle pulse to owner; cout valid that cycle
- cout  out  CWIDTH  result C, holds until next done
- err  out  1  one-cycle pulse on core timeout
- busy  out  1  grant != 0
- core_c  out  CWIDTH  to core .c
- core_reset  out  1  to core .reset (OR with global reset at instantiation)
- core_round  out  1  to core .round, constant 0
- core_cout  in  CWIDTH  from core .cout
- core_done  in  1  from core .done

Behaviour:
- Decided: reset reset, asynchronous, active-high; clock clk.
- Reset values: grant=0, done=0, cout=0, err=0, busy=0, core_c=0, core_reset=1; FSM=IDLE, last-owner pointer=1 (so port 0 wins first tie), round counter=0.
- States: IDLE, LOAD, RUN, NEXT, FINISH.
- IDLE:
  - If any req is set, pick a port. If only one is requesting, pick it. If both, pick the port != last owner.
  - Register grant, the work register W = cin of the winner, and cnt = nrounds of the winner.
  - If cnt==0, go to FINISH. Otherwise go to LOAD.
- LOAD (1 cycle): core_reset=1, core_c=W. Clear the timeout counter. Go to RUN.
- RUN:
  - core_reset=0 and core_c=W, held stable.
  - On core_done: W<=core_cout, cnt<=cnt-1, go to NEXT.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, pulse err, cout<=W, and go to FINISH (the op is aborted; done is still issued).
- NEXT: if cnt!=0, go to LOAD; else go to FINISH.
- FINISH (1 cycle):
  - done[owner]=1 and cout=W (registered).
  - Update the last-owner pointer, then grant<=0 and go to IDLE.
  - The next grant is issued no earlier than the cycle after FINISH (one idle bubble).
- Latency, from the first cycle req is seen in IDLE to done: 2 + n*(1 + core latency + 1) cycles for n>=1, and 2 cycles for n=0.
- req deasserted mid-operation is ignored: the operation completes and done still pulses.
- If req is still high in the cycle after done, it is a new request.
- Inputs cin*/nrounds* are don't-care except in the grant cycle.
- core_done asserted outside RUN is ignored.
- If core_done and the timeout threshold occur in the same cycle, core_done wins and no err is issued.
- Reset mid-operation: everything returns to reset values immediately. No done pulse; the requester re-requests.
- The arbiter never grants both ports. grant is one-hot or zero at all times.

Decomposition:
- Package gascon_arb_pkg:
  - state enum {IDLE, LOAD, RUN, NEXT, FINISH}
  - typedef port_idx_t (1 bit)
  - localparam NPORTS=2
- Sub-module gascon_rr_pick: combinational 2-way round-robin pick (req, last) -> one-hot winner. It is kept separate so it can be widened later.
- The Gascon core is instantiated by the parent, not inside this block.

Test Plan:
- Port 0 only, cin0=128'h1, nrounds0=3, core model with 2-cycle done -> exactly 3 core_reset pulses, then done=2'b01 with cout=f(f(f(1))), grant=01 throughout.
- Both req rise in the same cycle after reset -> port 0 served first. With both held, grants alternate 01,10,01, with one idle cycle between ops.
- nrounds1=0, cin1=128'hABCD -> done=2'b10 two cycles after req, cout=128'hABCD, no core_reset pulse.
- Core model never asserts done, TIMEOUT=64 -> err pulses after 64 RUN cycles, then done to the owner, then return to IDLE and serve the next request.
- Reset asserted during RUN of a 5-round op -> grant/done/cout go to 0 asynchronously. After release, a held req is re-granted and runs all 5 rounds.
- req0 dropped during RUN -> the op still completes and done[0] pulses. A pending req1 is granted next.
